// File: rtl/mmio_uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver: bus addresses,
// status bit positions, receiver state encoding and the parity helper.
package mmio_uart_rx_pkg;

   localparam logic [31:0] ADDR_DATA = 32'h4000_0018;
   localparam logic [31:0] ADDR_STAT = 32'h4000_001C;

   localparam int STAT_NE   = 0;
   localparam int STAT_FULL = 1;
   localparam int STAT_OVR  = 2;
   localparam int STAT_FERR = 3;
   localparam int STAT_PERR = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_e;

   // True when data plus parity bit hold an even number of ones.
   function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
      return ~(^data ^ par);
   endfunction

endpackage

// File: rtl/mmio_uart_rx_sync_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is only accepted when
// a pop happens on the same edge.
module sync_fifo #(
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

   logic [W-1:0]  mem_q [0:(1<<AW)-1];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push_s;
   logic          do_pop_s;

   assign full_o    = (count_q == DEPTH);
   assign empty_o   = (count_q == {(AW+1){1'b0}});
   assign dout_o    = mem_q[rd_ptr_q];
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/mmio_uart_rx.sv
// Memory-mapped UART receiver (8N1) with receive FIFO, status flags and irq.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module mmio_uart_rx
   import mmio_uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208,
   parameter int FIFO_AW      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic        mem_rd,
   input  logic [31:0] addr,
   output logic [31:0] rd_data,
   output logic        irq
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef UART_RX_PARITY_EN
   localparam logic PARITY_EN = 1'b1;
`else
   localparam logic PARITY_EN = 1'b0;
`endif

   logic            rx_meta_q, rx_sync_q;
   rx_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_bad_q, par_bad_d;
   logic            ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
   logic            push_s, ferr_set_s, perr_set_s, ovr_set_s;
   logic            pop_s, stat_rd_s, full_s, empty_s;
   logic [7:0]      head_s;

   sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (push_s),
      .pop_i  (pop_s),
      .din_i  (shift_q),
      .dout_o (head_s),
      .full_o (full_s),
      .empty_o(empty_s)
   );

   assign pop_s     = mem_rd & (addr == ADDR_DATA) & ~empty_s;
   assign stat_rd_s = mem_rd & (addr == ADDR_STAT);
   assign ovr_set_s = push_s & full_s & ~pop_s;
   assign irq       = ~empty_s;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_ONE;
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_bad_d  = par_bad_q;
      push_s     = 1'b0;
      ferr_set_s = 1'b0;
      perr_set_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (!rx_sync_q) begin
               state_d   = ST_START;
               bit_d     = 3'd0;
               par_bad_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            // Mid-bit re-sample rejects glitches shorter than half a bit.
            if (cnt_q == CNT_HALF) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = {CNT_W{1'b0}};
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = {CNT_W{1'b0}};
               par_bad_d = ~even_parity_ok(shift_q, rx_sync_q);
               state_d   = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = {CNT_W{1'b0}};
               perr_set_s = par_bad_q;
               if (rx_sync_q) begin
                  push_s  = ~par_bad_q;
                  state_d = ST_IDLE;
               end else begin
                  ferr_set_s = 1'b1;
                  state_d    = ST_WAIT_IDLE;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_WAIT_IDLE: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = rx_sync_q ? ST_IDLE : ST_WAIT_IDLE;
         end
         default: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_IDLE;
         end
      endcase
   end

   // A flag raised on the same edge as a status read survives the clear.
   always_comb begin
      ovr_d  = ovr_set_s  | (ovr_q  & ~stat_rd_s);
      ferr_d = ferr_set_s | (ferr_q & ~stat_rd_s);
      perr_d = perr_set_s | (perr_q & ~stat_rd_s);
   end

   always_comb begin
      rd_data = 32'h0000_0000;
      if (addr == ADDR_DATA) begin
         rd_data = {24'h00_0000, empty_s ? 8'h00 : head_s};
      end else if (addr == ADDR_STAT) begin
         rd_data = {27'h000_0000, perr_q, ferr_q, ovr_q, full_s, ~empty_s};
      end else begin
         rd_data = 32'h0000_0000;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         bit_q     <= 3'd0;
         shift_q   <= 8'h00;
         par_bad_q <= 1'b0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         ovr_q     <= ovr_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
      end
   end

endmodule
